// File: rtl/nco_quad.sv
// Quadrature NCO: phase accumulator with runtime FTW, phase offset and wrap pulse,
// feeding a quarter-wave ROM through a 3-stage pipeline (phase, ROM read, sign).
module nco_quad #(
  parameter int ACC_W  = 24,
  parameter int LUT_AW = 8,
  parameter int OUT_W  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [ACC_W-1:0]   ftw,
  input  logic               ftw_load,
  input  logic [ACC_W-1:0]   phase_off,
  input  logic               sync_clr,
  output logic [OUT_W-1:0]   sine,
  output logic [OUT_W-1:0]   cosine,
  output logic               out_valid,
  output logic               wrap
);

  localparam int IDX_W = LUT_AW - 2;
  localparam int DEPTH = 1 << IDX_W;
  localparam int MAG_W = OUT_W - 1;

  // Taylor series keeps ROM generation to plain real arithmetic; x stays within [0, pi/2].
  function automatic real sin_taylor(input real x);
    real term;
    real sum;
    term = x;
    sum  = x;
    for (int n = 1; n <= 10; n++) begin
      term = -term * x * x / (real'(2 * n) * real'(2 * n + 1));
      sum  = sum + term;
    end
    return sum;
  endfunction

  function automatic logic [MAG_W-1:0] rom_entry(input int k);
    real x;
    real v;
    x = 1.5707963267948966 * (real'(k) + 0.5) / real'(DEPTH);
    v = real'((1 << MAG_W) - 1) * sin_taylor(x);
    return MAG_W'($rtoi(v + 0.5));
  endfunction

  logic [MAG_W-1:0] rom [DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_rom
    localparam logic [MAG_W-1:0] QK = rom_entry(k);
    assign rom[k] = QK;
  end

  // Accumulator and stage 1
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  ftw_act;
  logic [ACC_W:0]    step_sum;
  logic [ACC_W-1:0]  phase;
  logic              s1_valid;
  logic [LUT_AW-1:0] s1_a;

  assign step_sum = {1'b0, acc} + {1'b0, ftw_act};
  assign phase    = acc + phase_off;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      ftw_act  <= '0;
      wrap     <= 1'b0;
      s1_valid <= 1'b0;
    end else begin
      if (ftw_load) ftw_act <= ftw;
      wrap     <= 1'b0;
      s1_valid <= en;
      if (sync_clr) begin
        acc <= '0;
      end else if (en) begin
        acc  <= step_sum[ACC_W-1:0];
        wrap <= step_sum[ACC_W];
      end
    end
  end

  // NOTE: datapath registers carry no reset; the valid bits alone decide whether their contents matter.
  always_ff @(posedge clk) begin
    if (en) s1_a <= LUT_AW'(phase >> (ACC_W - LUT_AW));
  end

  // Stage 2: quadrant mirroring and ROM read for both outputs
  logic [1:0]       q_sin;
  logic [1:0]       q_cos;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] sin_idx;
  logic [IDX_W-1:0] cos_idx;
  logic             s2_valid;
  logic [MAG_W-1:0] s2_sin_mag;
  logic [MAG_W-1:0] s2_cos_mag;
  logic             s2_sin_neg;
  logic             s2_cos_neg;

  assign q_sin   = s1_a[LUT_AW-1 -: 2];
  assign q_cos   = q_sin + 2'd1;
  assign idx     = s1_a[IDX_W-1:0];
  assign sin_idx = q_sin[0] ? ~idx : idx;
  assign cos_idx = q_cos[0] ? ~idx : idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s2_valid <= 1'b0;
    else        s2_valid <= s1_valid;
  end

  always_ff @(posedge clk) begin
    if (s1_valid) begin
      s2_sin_mag <= rom[sin_idx];
      s2_cos_mag <= rom[cos_idx];
      s2_sin_neg <= q_sin[1];
      s2_cos_neg <= q_cos[1];
    end
  end

  // Stage 3: sign application; outputs hold between samples
  logic [OUT_W-1:0] sin_ext;
  logic [OUT_W-1:0] cos_ext;

  assign sin_ext = {1'b0, s2_sin_mag};
  assign cos_ext = {1'b0, s2_cos_mag};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sine      <= '0;
      cosine    <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        sine   <= s2_sin_neg ? -sin_ext : sin_ext;
        cosine <= s2_cos_neg ? -cos_ext : cos_ext;
      end
    end
  end

endmodule

// File: tb/tb_nco_quad.sv
// Scoreboard bench for nco_quad: the driver models the accumulator and queues expected
// samples; a negedge monitor pops and compares whenever out_valid is high.
module tb_nco_quad;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [23:0] ftw = '0;
  logic        ftw_load = 1'b0;
  logic [23:0] phase_off = '0;
  logic        sync_clr = 1'b0;
  logic [7:0]  sine;
  logic [7:0]  cosine;
  logic        out_valid;
  logic        wrap;

  nco_quad #(.ACC_W(24), .LUT_AW(8), .OUT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .ftw       (ftw),
    .ftw_load  (ftw_load),
    .phase_off (phase_off),
    .sync_clr  (sync_clr),
    .sine      (sine),
    .cosine    (cosine),
    .out_valid (out_valid),
    .wrap      (wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    int id;
    int s;
    int c;
    int stamp;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   n_id     = 0;
  int   wrap_cnt = 0;
  int   log_s [1024];
  int   log_c [1024];

  logic [23:0] m_acc = '0;
  logic [23:0] m_ftw = '0;
  logic        exp_wrap = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic int q_tab(input int k);
    real v;
    v = 127.0 * $sin(3.14159265358979 * (real'(k) + 0.5) / 128.0);
    return $rtoi(v + 0.5);
  endfunction

  function automatic int exp_val(input logic [7:0] a, input bit is_cos);
    logic [1:0] qd;
    int         i;
    int         mag;
    qd  = a[7:6] + {1'b0, is_cos};
    i   = int'(a[5:0]);
    mag = qd[0] ? q_tab(63 - i) : q_tab(i);
    return qd[1] ? -mag : mag;
  endfunction

  // One clock of stimulus, entered and left at a negedge.
  task automatic step(input logic e, input logic ld, input logic [23:0] f,
                      input logic [23:0] po, input logic clr);
    logic [24:0] sum;
    logic [23:0] ph;
    exp_t        x;
    en = e; ftw_load = ld; ftw = f; phase_off = po; sync_clr = clr;
    exp_wrap = 1'b0;
    if (e) begin
      ph      = m_acc + po;
      x.id    = n_id;
      x.s     = exp_val(ph[23:16], 1'b0);
      x.c     = exp_val(ph[23:16], 1'b1);
      x.stamp = cyc + 3;
      q.push_back(x);
      n_id++;
    end
    sum = {1'b0, m_acc} + {1'b0, m_ftw};
    if (clr) m_acc = '0;
    else if (e) begin
      m_acc    = sum[23:0];
      exp_wrap = sum[24];
    end
    if (ld) m_ftw = f;
    @(posedge clk);
    @(negedge clk);
    en = 1'b0; ftw_load = 1'b0; sync_clr = 1'b0;
    check("wrap", wrap, exp_wrap);
    if (wrap) wrap_cnt++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 24'd0, 24'd0, 1'b0);
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && q.size() != 0; k++) idle(1);
    check("drain_empty", q.size(), 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_valid: got out_valid=1 expected no sample (t=%0t)", $time);
      end else begin
        e = q.pop_front();
        check("latency", cyc, e.stamp);
        check("sine", $signed(sine), e.s);
        check("cosine", $signed(cosine), e.c);
        log_s[e.id] = $signed(sine);
        log_c[e.id] = $signed(cosine);
      end
    end
  end

  initial begin
    int id_first, base, id_off, id_ld, id_clr, id_rec;
    for (int k = 0; k < 1024; k++) begin log_s[k] = 999; log_c[k] = 999; end

    // Reset state
    @(negedge clk); @(negedge clk);
    check("rst_sine", sine, 0);
    check("rst_cosine", cosine, 0);
    check("rst_valid", out_valid, 0);
    check("rst_wrap", wrap, 0);
    rst_n = 1'b1;

    // Single sample at phase 0
    step(1'b0, 1'b1, 24'd0, 24'd0, 1'b0);
    id_first = n_id;
    step(1'b1, 1'b0, 24'd0, 24'd0, 1'b0);
    idle(5);
    drain();
    check("first_sine", log_s[id_first], 2);
    check("first_cos", log_c[id_first], 127);
    check("hold_sine", $signed(sine), 2);
    check("hold_cos", $signed(cosine), 127);

    // Sweep with ftw = 2^16
    step(1'b0, 1'b1, 24'h010000, 24'd0, 1'b0);
    base = n_id;
    wrap_cnt = 0;
    for (int k = 0; k < 300; k++) step(1'b1, 1'b0, 24'd0, 24'd0, 1'b0);
    drain();
    check("sweep_wraps", wrap_cnt, 1);
    check("sweep63_sine", log_s[base + 63], 127);
    check("sweep64_sine", log_s[base + 64], 127);
    check("sweep64_cos", log_c[base + 64], -2);
    check("sweep128_sine", log_s[base + 128], -2);
    check("sweep128_cos", log_c[base + 128], -127);

    // Phase offset of a quarter cycle
    step(1'b0, 1'b1, 24'd0, 24'd0, 1'b1);
    id_off = n_id;
    step(1'b1, 1'b0, 24'd0, 24'h400000, 1'b0);
    drain();
    check("off_sine", log_s[id_off], 127);
    check("off_cos", log_c[id_off], -2);

    // FTW load coincident with en: that step keeps the old (zero) FTW
    id_ld = n_id;
    step(1'b1, 1'b1, 24'h010000, 24'd0, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 24'd0, 24'd0, 1'b0);
    drain();
    check("ld0_sine", log_s[id_ld], 2);
    check("ld1_sine", log_s[id_ld + 1], 2);
    check("ld2_sine", log_s[id_ld + 2], 5);
    check("ld3_sine", log_s[id_ld + 3], 8);
    check("ld3_cos", log_c[id_ld + 3], 127);

    // sync_clr with en at a value whose step would carry
    step(1'b0, 1'b1, 24'hFF0000, 24'd0, 1'b1);
    step(1'b1, 1'b0, 24'd0, 24'd0, 1'b0);
    id_clr = n_id;
    wrap_cnt = 0;
    step(1'b1, 1'b0, 24'd0, 24'd0, 1'b1);
    check("clr_no_wrap", wrap_cnt, 0);
    step(1'b1, 1'b0, 24'd0, 24'd0, 1'b0);
    step(1'b1, 1'b0, 24'd0, 24'd0, 1'b0);
    check("carry_wrap", wrap_cnt, 1);
    drain();
    check("clr_sine", log_s[id_clr], -2);
    check("clr_cos", log_c[id_clr], 127);
    check("after_clr_sine", log_s[id_clr + 1], 2);
    check("after_clr_cos", log_c[id_clr + 1], 127);
    check("carry_sine", log_s[id_clr + 2], -2);

    // Reset with samples in flight
    step(1'b1, 1'b0, 24'd0, 24'd0, 1'b0);
    step(1'b1, 1'b0, 24'd0, 24'd0, 1'b0);
    en = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_sine", sine, 0);
    check("midrst_cosine", cosine, 0);
    check("midrst_valid", out_valid, 0);
    check("midrst_wrap", wrap, 0);
    q.delete();
    en = 1'b0;
    m_acc = '0;
    m_ftw = '0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      idle(1);
      check("post_rst_valid", out_valid, 0);
    end
    id_rec = n_id;
    step(1'b1, 1'b0, 24'd0, 24'd0, 1'b0);
    drain();
    check("rec_sine", log_s[id_rec], 2);
    check("rec_cos", log_c[id_rec], 127);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end of test expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/nco_quad.md
# nco_quad

Parametrised quadrature numerically controlled oscillator, the successor to the single-output 8-bit-LUT NCO in the DSP chain. It provides a configurable-width phase accumulator, a runtime frequency-tuning-word load, a phase offset, a synchronous phase clear and a wrap pulse. Signed sine and cosine are produced from an internal quarter-wave ROM through a 3-stage pipeline with an output valid. It feeds mixers and modulators, one sample per `en` strobe.

## Interface
- `ACC_W`, 24, phase accumulator width; `ftw` and `phase_off` share it.
- `LUT_AW`, 8, full-cycle phase resolution in bits; ROM depth is 2^(LUT_AW-2); requires LUT_AW ≥ 4 and ACC_W ≥ LUT_AW.
- `OUT_W`, 8, output sample width, two's complement.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  sample strobe; one accumulator step and one output sample per high cycle.
- `ftw`  in  ACC_W  frequency tuning word, unsigned.
- `ftw_load`  in  1  captures `ftw` into the active tuning register.
- `phase_off`  in  ACC_W  phase offset added at sampling; not registered; sampled only on `en` cycles.
- `sync_clr`  in  1  synchronous accumulator clear.
- `sine`  out  OUT_W  signed sine sample.
- `cosine`  out  OUT_W  signed cosine sample.
- `out_valid`  out  1  `sine`/`cosine` updated this cycle.
- `wrap`  out  1  one-cycle pulse on accumulator overflow.

## Operation
- Registers: `acc` (ACC_W), `ftw_act` (ACC_W), 3 pipeline stages each with a valid bit.
- `ftw_load` high: `ftw_act <= ftw`. If `en` is high in the same cycle, the step in that cycle uses the old `ftw_act`.
- Stage 1, on `en`: `p = (acc + phase_off) mod 2^ACC_W`, using `acc` before this cycle's step. In the same edge, `{carry, acc} <= acc + ftw_act`.
- Phase clear: `sync_clr` overrides the step and sets `acc <= 0` whatever the value of `en`.
  - If `en` is also high, stage 1 still samples the pre-clear `acc`.
  - No wrap is generated for that cycle.
- `en` low: `acc` holds and no sample enters the pipeline.
- Address split: `a = p[ACC_W-1 -: LUT_AW]`.
  - Quadrant `q = a[LUT_AW-1:LUT_AW-2]`; index `i = a[LUT_AW-3:0]`.
  - Cosine uses `qc = q+1 mod 4` with the same `i`.
- Quadrant mapping, applied per output:
  - q0: `+Q[i]`
  - q1: `+Q[~i]`
  - q2: `-Q[i]`
  - q3: `-Q[~i]`
- ROM contents: `Q[k] = round((2^(OUT_W-1)-1) * sin(pi/2 * (k+0.5) / 2^(LUT_AW-2)))`, computed at elaboration.
  - Values are in 0..2^(OUT_W-1)-1, so negation never overflows.
  - The half-step offset makes the mirroring exact.
- Stage 2: registered ROM read for both outputs (two read ports or duplicated ROM).
- Stage 3: conditional negation, registered into `sine`/`cosine`.
- Pipeline stages advance every cycle; they are not gated by `en`.

## Timing
- Reset (async, immediate) clears:
  - `acc`, `ftw_act` and all pipeline valids to 0.
  - `sine`, `cosine`, `out_valid` and `wrap` to 0.
- Latency: `en` at edge N gives `out_valid=1` with the new samples after edge N+3.
  - Back-to-back `en` gives one sample per cycle.
- Outputs hold their value while `out_valid=0`.
- `wrap` is registered: it is high for the cycle after an `en` edge whose step carried out of bit ACC_W-1.
- Reset mid-operation: in-flight samples are discarded and no `out_valid` follows reset release until a new `en`.

## Test plan
- Reset, then `ftw_load` with `ftw=0`, then a single `en` with `phase_off=0`:
  - `out_valid` is high exactly 3 cycles later.
  - `sine=2`, `cosine=127`.
- `ftw=2^16`, `en` held high:
  - `sine` steps one ROM address per sample, reaching 127 at sample 64 (idx 63/q0 to q1 boundary).
  - `wrap` pulses once every 256 enables.
  - Sample 128 gives `sine=-2`.
- `phase_off=2^22` with `ftw=0`: first sample gives `sine=127`, `cosine=-2`.
- Mid-stream `ftw_load` coincident with `en`:
  - That step uses the old FTW.
  - The following step uses the new FTW; check `acc` via the sample sequence.
- `sync_clr` with `en` high at `acc≠0`:
  - The emitted sample reflects the old `acc`.
  - The next sample is the phase-0 sample (2/127).
  - No `wrap` is generated.
- Assert `rst_n` low while 3 samples are in flight: outputs go to 0 immediately, and after release no `out_valid` appears without `en`.
